// File: rtl/uart_rx_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_rx_param
// Brief   : 16x-oversampled UART receiver with 3-sample majority voting,
//           optional parity, break handling and a ready/valid holding stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_DIV    = 326,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam int                  c_TICK_W   = 10;
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(CLK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE = c_TICK_W'(1);
    localparam logic [3:0]          c_LAST_BIT = 4'(DATA_BITS - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rxs_prev_q;
    logic                 rxs;

    logic [2:0]           state_q, state_d;
    logic [c_TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [3:0]           samp_q, samp_d;
    logic [3:0]           bit_q, bit_d;
    logic                 m7_q, m7_d;
    logic                 m8_q, m8_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_pend_q, perr_pend_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 tick;
    logic                 fall;
    logic                 at_s7;
    logic                 at_s8;
    logic                 at_s9;
    logic                 at_wrap;
    logic                 maj;
    logic                 par_exp;
    logic                 stop_done;

    // Synchronizer plus one more stage for falling-edge detection on rxs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_in;
            sync2_q    <= sync1_q;
            rxs_prev_q <= sync2_q;
        end
    end

    assign rxs = sync2_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (fall) begin
                    state_d = c_START;
                end
            end
            c_START: begin
                if (at_s9 && maj) begin
                    state_d = c_IDLE;
                end else if (at_wrap) begin
                    state_d = c_DATA;
                end
            end
            c_DATA: begin
                if (at_wrap && (bit_q == c_LAST_BIT)) begin
                    state_d = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                end
            end
            c_PARITY: begin
                if (at_wrap) begin
                    state_d = c_STOP;
                end
            end
            c_STOP: begin
                // Leave at the stop sample so a following start edge is not missed.
                if (at_s9) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != c_IDLE);
        tick    = (tick_cnt_q == c_TICK_MAX);
        fall    = (state_q == c_IDLE) && rxs_prev_q && !rxs;
        at_s7   = tick && (samp_q == 4'd7);
        at_s8   = tick && (samp_q == 4'd8);
        at_s9   = tick && (samp_q == 4'd9);
        at_wrap = tick && (samp_q == 4'd15);
        maj     = (m7_q & m8_q) | (m7_q & rxs) | (m8_q & rxs);
    end

    generate
        if (PARITY_EN != 0) begin : g_parity
            assign par_exp = (^shreg_q) ^ (PARITY_ODD != 0);
        end else begin : g_no_parity
            assign par_exp = 1'b0;
        end
    endgenerate

    always_comb begin
        tick_cnt_d = tick ? '0 : (tick_cnt_q + c_TICK_ONE);
        samp_d     = samp_q;
        if (fall) begin
            tick_cnt_d = '0;
            samp_d     = '0;
        end else if (busy && tick) begin
            samp_d = samp_q + 4'd1;
        end

        m7_d = at_s7 ? rxs : m7_q;
        m8_d = at_s8 ? rxs : m8_q;

        bit_d       = bit_q;
        shreg_d     = shreg_q;
        perr_pend_d = perr_pend_q;
        if (state_q == c_START) begin
            bit_d       = '0;
            perr_pend_d = 1'b0;
        end
        if ((state_q == c_DATA) && at_wrap) begin
            bit_d = bit_q + 4'd1;
        end
        if ((state_q == c_DATA) && at_s9) begin
            shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        end
        if ((state_q == c_PARITY) && at_s9) begin
            perr_pend_d = (maj != par_exp);
        end
    end

    always_comb begin
        stop_done    = (state_q == c_STOP) && at_s9;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (stop_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                rx_valid_d   = 1'b1;
                parity_err_d = perr_pend_q && (PARITY_EN != 0);
                frame_err_d  = !maj;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tick_cnt_q   <= '0;
            samp_q       <= '0;
            bit_q        <= '0;
            m7_q         <= 1'b0;
            m8_q         <= 1'b0;
            shreg_q      <= '0;
            perr_pend_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            m7_q         <= m7_d;
            m8_q         <= m8_d;
            shreg_q      <= shreg_d;
            perr_pend_q  <= perr_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_rx_param
// Brief   : Directed bench for uart_rx_param: frame table plus glitch,
//           overrun, break and mid-frame reset sequences.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int c_CD  = 4;
    localparam int c_BIT = 16 * c_CD;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_DIV   (c_CD),
        .DATA_BITS (8),
        .PARITY_EN (0),
        .PARITY_ODD(0)
    ) u_dut_a (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .rx_in     (rx_a),
        .rx_data   (data_a),
        .rx_valid  (valid_a),
        .rx_ready  (ready_a),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .overrun   (ovr_a),
        .busy      (busy_a)
    );

    uart_rx_param #(
        .CLK_DIV   (c_CD),
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) u_dut_b (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .rx_in     (rx_b),
        .rx_data   (data_b),
        .rx_valid  (valid_b),
        .rx_ready  (ready_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .overrun   (ovr_b),
        .busy      (busy_b)
    );

    // Edge counter and output event monitor, updated just after each rising edge.
    int   cyc = 0;
    int   rise_a = 0, rise_b = 0;
    int   rcyc_a = 0, rcyc_b = 0;
    int   hi_a = 0, hi_b = 0;
    int   ovr_cnt_a = 0;
    logic pv_a = 1'b0, pv_b = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (valid_a) hi_a = hi_a + 1;
        if (valid_b) hi_b = hi_b + 1;
        if (valid_a && !pv_a) begin
            rise_a = rise_a + 1;
            rcyc_a = cyc;
        end
        if (valid_b && !pv_b) begin
            rise_b = rise_b + 1;
            rcyc_b = cyc;
        end
        if (ovr_a) ovr_cnt_a = ovr_cnt_a + 1;
        pv_a = valid_a;
        pv_b = valid_b;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    // Line 1 feeds the parity-enabled receiver, so it gets a parity bit.
    task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                              input logic sbit, input int idle_bits, output int c0);
        c0 = cyc;
        set_line(which, 1'b0);
        wait_clk(c_BIT);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            wait_clk(c_BIT);
        end
        if (which == 1) begin
            set_line(which, pbit);
            wait_clk(c_BIT);
        end
        set_line(which, sbit);
        wait_clk(c_BIT);
        set_line(which, 1'b1);
        wait_clk(idle_bits * c_BIT);
    endtask

    typedef struct {
        int         which;
        logic [7:0] d;
        logic       pbit;
        logic       sbit;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c0, r0, h0, o0, lat_exp;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[7] = '{1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        rst_n   = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        wait_clk(5);
        chk("reset rx_data", int'(data_a), 0);
        chk("reset rx_valid", int'(valid_a), 0);
        chk("reset parity_err", int'(perr_a), 0);
        chk("reset frame_err", int'(ferr_a), 0);
        chk("reset overrun", int'(ovr_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset busy b", int'(busy_b), 0);
        rst_n = 1'b1;
        wait_clk(10);

        for (int i = 0; i < 8; i++) begin
            r0 = (vecs[i].which == 0) ? rise_a : rise_b;
            h0 = (vecs[i].which == 0) ? hi_a : hi_b;
            send_frame(vecs[i].which, vecs[i].d, vecs[i].pbit, vecs[i].sbit, 2, c0);
            lat_exp = 2 + (9 + vecs[i].which) * c_BIT + 10 * c_CD + 1;
            if (vecs[i].which == 0) begin
                chk($sformatf("v%0d valid count", i), rise_a - r0, 1);
                chk($sformatf("v%0d latency", i), rcyc_a - c0, lat_exp);
                chk($sformatf("v%0d valid width", i), hi_a - h0, 1);
                chk($sformatf("v%0d rx_data", i), int'(data_a), int'(vecs[i].exp_d));
                chk($sformatf("v%0d parity_err", i), int'(perr_a), int'(vecs[i].exp_pe));
                chk($sformatf("v%0d frame_err", i), int'(ferr_a), int'(vecs[i].exp_fe));
            end else begin
                chk($sformatf("v%0d valid count", i), rise_b - r0, 1);
                chk($sformatf("v%0d latency", i), rcyc_b - c0, lat_exp);
                chk($sformatf("v%0d valid width", i), hi_b - h0, 1);
                chk($sformatf("v%0d rx_data", i), int'(data_b), int'(vecs[i].exp_d));
                chk($sformatf("v%0d parity_err", i), int'(perr_b), int'(vecs[i].exp_pe));
                chk($sformatf("v%0d frame_err", i), int'(ferr_b), int'(vecs[i].exp_fe));
            end
        end

        // 20-clock glitch: START aborts at the count-9 sample.
        r0   = rise_a;
        c0   = cyc;
        rx_a = 1'b0;
        wait_clk(20);
        rx_a = 1'b1;
        wait_clk(22);
        chk("glitch busy before abort", int'(busy_a), 1);
        wait_clk(1);
        chk("glitch busy after abort", int'(busy_a), 0);
        wait_clk(200);
        chk("glitch no valid", rise_a - r0, 0);
        chk("glitch rx_data kept", int'(data_a), 8'h3C);

        // Back-to-back frames while the consumer stalls.
        ready_a = 1'b0;
        r0      = rise_a;
        o0      = ovr_cnt_a;
        send_frame(0, 8'h55, 1'b0, 1'b1, 0, c0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 3, c0);
        chk("b2b valid count", rise_a - r0, 1);
        chk("b2b overrun pulses", ovr_cnt_a - o0, 1);
        chk("b2b valid held", int'(valid_a), 1);
        chk("b2b rx_data held", int'(data_a), 8'h55);
        chk("b2b frame_err", int'(ferr_a), 0);
        ready_a = 1'b1;
        wait_clk(1);
        chk("b2b valid cleared", int'(valid_a), 0);
        chk("b2b rx_data after accept", int'(data_a), 8'h55);

        // Break: line low for 12 bit times.
        r0   = rise_a;
        c0   = cyc;
        rx_a = 1'b0;
        wait_clk(12 * c_BIT);
        chk("break valid count", rise_a - r0, 1);
        chk("break latency", rcyc_a - c0, 2 + 9 * c_BIT + 10 * c_CD + 1);
        chk("break rx_data", int'(data_a), 0);
        chk("break frame_err", int'(ferr_a), 1);
        chk("break idle while low", int'(busy_a), 0);
        rx_a = 1'b1;
        wait_clk(2 * c_BIT);
        chk("break no second frame", rise_a - r0, 1);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 2, c0);
        chk("post-break valid count", rise_a - r0, 2);
        chk("post-break rx_data", int'(data_a), 8'h5A);
        chk("post-break frame_err", int'(ferr_a), 0);

        // Reset in the middle of data bit 4 of 0xFF.
        r0   = rise_a;
        rx_a = 1'b0;
        wait_clk(c_BIT);
        rx_a = 1'b1;
        wait_clk(4 * c_BIT + c_BIT / 2);
        chk("midreset busy before", int'(busy_a), 1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midreset rx_data", int'(data_a), 0);
        chk("midreset rx_valid", int'(valid_a), 0);
        chk("midreset parity_err", int'(perr_a), 0);
        chk("midreset frame_err", int'(ferr_a), 0);
        chk("midreset overrun", int'(ovr_a), 0);
        chk("midreset busy", int'(busy_a), 0);
        rst_n = 1'b1;
        wait_clk(6 * c_BIT);
        chk("midreset no output", rise_a - r0, 0);
        chk("midreset idle", int'(busy_a), 0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 2, c0);
        chk("after reset valid count", rise_a - r0, 1);
        chk("after reset latency", rcyc_a - c0, 2 + 9 * c_BIT + 10 * c_CD + 1);
        chk("after reset rx_data", int'(data_a), 8'h81);
        chk("after reset frame_err", int'(ferr_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
